// File: rtl/si_link_arbiter.sv
`default_nettype none
// ============================================================================
// si_link_arbiter : schedules the shared sen/sd link between upload and
//                   download endpoints, counts frames, flags link faults.
// Revision        : 1.0
// ============================================================================
module si_link_arbiter #(
  parameter int UP_BITS   = 21,
  parameter int DN_BITS   = 13,
  parameter int MAX_BURST = 18,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_req,
  input  logic [4:0] up_frames,
  input  logic       dn_req,
  input  logic [4:0] dn_frames,
  input  logic       sen,
  input  logic       err_clr,
  output logic       up_gnt,
  output logic       dn_gnt,
  output logic       updown,
  output logic [4:0] frame_cnt,
  output logic       burst_done,
  output logic       frame_err,
  output logic       timeout_err
);

  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_GRANT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           winner_q, winner_d;
  logic           last_owner_q, last_owner_d;
  logic           updown_q, updown_d;
  logic [4:0]     target_q, target_d;
  logic [4:0]     frame_cnt_q, frame_cnt_d;
  logic [4:0]     bitcnt_q, bitcnt_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic           frame_err_q, frame_err_d;
  logic           timeout_err_q, timeout_err_d;

  logic           up_valid, dn_valid, pick, win_req, exit_grant;
  logic           set_ferr, set_terr;
  logic [4:0]     pick_frames, last_bit;

  assign up_valid    = up_req && (up_frames != 5'd0);
  assign dn_valid    = dn_req && (dn_frames != 5'd0);
  // Tie goes to the endpoint that did not own the previous burst.
  assign pick        = (up_valid && dn_valid) ? ~last_owner_q : dn_valid;
  assign pick_frames = pick ? dn_frames : up_frames;
  assign win_req     = winner_q ? dn_req : up_req;
  assign last_bit    = winner_q ? 5'(DN_BITS - 1) : 5'(UP_BITS - 1);

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_owner_d = last_owner_q;
    updown_d     = updown_q;
    target_d     = target_q;
    frame_cnt_d  = frame_cnt_q;
    bitcnt_d     = bitcnt_q;
    idle_d       = idle_q;
    set_ferr     = 1'b0;
    set_terr     = 1'b0;
    exit_grant   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (up_valid || dn_valid) begin
          winner_d    = pick;
          target_d    = (pick_frames > 5'(MAX_BURST)) ? 5'(MAX_BURST) : pick_frames;
          frame_cnt_d = 5'd0;
          bitcnt_d    = 5'd0;
          idle_d      = '0;
          state_d     = S_TURN;
        end
      end
      S_TURN: begin
        updown_d = winner_q;
        state_d  = S_GRANT;
      end
      S_GRANT: begin
        if (!sen) begin
          idle_d = '0;
          if (bitcnt_q == last_bit) begin
            bitcnt_d    = 5'd0;
            frame_cnt_d = frame_cnt_q + 5'd1;
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else begin
          idle_d   = idle_q + 1'b1;
          bitcnt_d = 5'd0;
          set_ferr = (bitcnt_q != 5'd0);
        end
        if (idle_q == IW'(TIMEOUT - 1)) begin
          exit_grant = 1'b1;
          set_terr   = 1'b1;
        end
        // A dropped request only ends the burst between frames.
        if (!win_req && (bitcnt_q == 5'd0)) exit_grant = 1'b1;
        if (frame_cnt_d == target_q)        exit_grant = 1'b1;
        if (exit_grant) state_d = S_DONE;
      end
      default: begin
        last_owner_d = winner_q;
        state_d      = S_IDLE;
      end
    endcase

    frame_err_d   = set_ferr | (frame_err_q   & ~err_clr);
    timeout_err_d = set_terr | (timeout_err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      winner_q      <= 1'b0;
      last_owner_q  <= 1'b1;
      updown_q      <= 1'b0;
      target_q      <= 5'd0;
      frame_cnt_q   <= 5'd0;
      bitcnt_q      <= 5'd0;
      idle_q        <= '0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_owner_q  <= last_owner_d;
      updown_q      <= updown_d;
      target_q      <= target_d;
      frame_cnt_q   <= frame_cnt_d;
      bitcnt_q      <= bitcnt_d;
      idle_q        <= idle_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign up_gnt      = (state_q == S_GRANT) && !winner_q;
  assign dn_gnt      = (state_q == S_GRANT) &&  winner_q;
  assign updown      = updown_q;
  assign frame_cnt   = frame_cnt_q;
  assign burst_done  = (state_q == S_DONE);
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_si_link_arbiter.sv
`default_nettype none
// tb_si_link_arbiter: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the link scheduler.
module tb_si_link_arbiter;
  localparam int UP_BITS = 21, DN_BITS = 13, MAX_BURST = 18, TIMEOUT = 64;

  logic       clk = 1'b0, rst = 1'b1;
  logic       up_req = 1'b0, dn_req = 1'b0, sen = 1'b0, err_clr = 1'b0;
  logic [4:0] up_frames = 5'd0, dn_frames = 5'd0;
  logic       up_gnt, dn_gnt, updown, burst_done, frame_err, timeout_err;
  logic [4:0] frame_cnt;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  si_link_arbiter #(.UP_BITS(UP_BITS), .DN_BITS(DN_BITS), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .up_req(up_req), .up_frames(up_frames), .dn_req(dn_req),
    .dn_frames(dn_frames), .sen(sen), .err_clr(err_clr), .up_gnt(up_gnt), .dn_gnt(dn_gnt),
    .updown(updown), .frame_cnt(frame_cnt), .burst_done(burst_done), .frame_err(frame_err),
    .timeout_err(timeout_err));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 turnaround, 2 link owned, 3 burst end.
  int m_phase, m_win, m_last, m_upd, m_fc, m_target, m_bits, m_idle, m_ferr, m_terr;
  bit m_valid = 0;
  bit m_uv, m_dv, m_req, m_leave, m_setf, m_sett;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_last = 1; m_upd = 0; m_fc = 0; m_win = 0;
      m_bits = 0; m_idle = 0; m_ferr = 0; m_terr = 0; m_valid = 1;
    end else begin
      m_setf = 0; m_sett = 0;
      case (m_phase)
        0: begin
          m_uv = up_req && up_frames != 0;
          m_dv = dn_req && dn_frames != 0;
          if (m_uv || m_dv) begin
            m_win    = (m_uv && m_dv) ? 1 - m_last : (m_dv ? 1 : 0);
            m_target = m_win ? int'(dn_frames) : int'(up_frames);
            if (m_target > MAX_BURST) m_target = MAX_BURST;
            m_fc = 0; m_bits = 0; m_idle = 0; m_phase = 1;
          end
        end
        1: begin m_upd = m_win; m_phase = 2; end
        2: begin
          m_req   = m_win ? dn_req : up_req;
          m_leave = !m_req && m_bits == 0;
          if (m_idle == TIMEOUT - 1) begin m_leave = 1; m_sett = 1; end
          if (!sen) begin
            m_idle = 0;
            m_bits++;
            if (m_bits == (m_win ? DN_BITS : UP_BITS)) begin m_fc++; m_bits = 0; end
          end else begin
            m_idle++;
            if (m_bits != 0) m_setf = 1;
            m_bits = 0;
          end
          if (m_fc == m_target) m_leave = 1;
          if (m_leave) m_phase = 3;
        end
        default: begin m_last = m_win; m_phase = 0; end
      endcase
      if (err_clr) begin m_ferr = 0; m_terr = 0; end
      if (m_setf) m_ferr = 1;
      if (m_sett) m_terr = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("up_gnt",      up_gnt,      (m_phase == 2 && m_win == 0));
      chk("dn_gnt",      dn_gnt,      (m_phase == 2 && m_win == 1));
      chk("updown",      updown,      m_upd);
      chk("frame_cnt",   frame_cnt,   m_fc);
      chk("burst_done",  burst_done,  (m_phase == 3));
      chk("frame_err",   frame_err,   m_ferr);
      chk("timeout_err", timeout_err, m_terr);
      chk("gnt_overlap", up_gnt & dn_gnt, 0);
    end
  end

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (burst_done !== 1'b1 && cyc < budget) begin @(negedge clk); cyc++; end
    tests++;
    if (burst_done !== 1'b1) begin
      fails++;
      $display("FAIL burst_done_wait: got no pulse expected pulse within %0d cycles", budget);
    end
  endtask

  task automatic wait_gnt(input int budget);
    int c;
    c = 0;
    while (up_gnt !== 1'b1 && dn_gnt !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    tests++;
    if (up_gnt !== 1'b1 && dn_gnt !== 1'b1) begin
      fails++;
      $display("FAIL grant_wait: got no grant expected grant within %0d cycles", budget);
    end
  endtask

  int cyc, run_left;
  bit any_gnt;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_up_gnt", up_gnt, 0);
    chk("rst_dn_gnt", dn_gnt, 0);
    chk("rst_updown", updown, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_burst_done", burst_done, 0);
    rst = 1'b0;

    // Upload only, 8 clean frames.
    up_frames = 5'd8; up_req = 1'b1;
    @(negedge clk); chk("up_lat1_gnt", up_gnt, 0);
    @(negedge clk); chk("up_lat2_gnt", up_gnt, 1); chk("up_updown", updown, 0);
    wait_done(400, cyc);
    chk("up_len", cyc, 8 * UP_BITS);
    chk("up_cnt", frame_cnt, 8);
    chk("model_up_cnt", m_fc, 8);
    chk("up_gnt_off", up_gnt, 0);
    up_req = 1'b0;

    // Tie right after reset: upload first, then 18 download frames.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    up_req = 1'b1; up_frames = 5'd2; dn_req = 1'b1; dn_frames = 5'd18;
    repeat (2) @(negedge clk);
    chk("tie_up_first", up_gnt, 1);
    chk("tie_dn_wait", dn_gnt, 0);
    wait_done(200, cyc);
    chk("tie_up_len", cyc, 2 * UP_BITS);
    up_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("tie_dn_gnt", dn_gnt, 1);
    chk("tie_dn_updown", updown, 1);
    wait_done(400, cyc);
    chk("tie_dn_len", cyc, 18 * DN_BITS);
    chk("tie_dn_cnt", frame_cnt, 18);
    dn_req = 1'b0;

    // Round robin over four back-to-back ties.
    up_req = 1'b1; dn_req = 1'b1; up_frames = 5'd1; dn_frames = 5'd1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(10);
      chk("rr_owner", dn_gnt, i % 2);
      chk("model_rr_owner", m_win, i % 2);
      wait_done(40, cyc);
    end
    up_req = 1'b0; dn_req = 1'b0;

    // Framing fault after 10 bits, then two clean frames.
    up_req = 1'b1; up_frames = 5'd2;
    wait_gnt(10);
    repeat (10) @(negedge clk);
    sen = 1'b1; @(negedge clk); sen = 1'b0;
    chk("ferr_set", frame_err, 1);
    chk("ferr_cnt_zero", frame_cnt, 0);
    wait_done(100, cyc);
    chk("ferr_cnt", frame_cnt, 2);
    up_req = 1'b0;

    // Idle timeout with sen held high, then clear both flags.
    up_req = 1'b1; up_frames = 5'd1; sen = 1'b1;
    wait_gnt(10);
    wait_done(100, cyc);
    chk("tmo_len", cyc, TIMEOUT);
    chk("tmo_set", timeout_err, 1);
    up_req = 1'b0; sen = 1'b0; err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_ferr", frame_err, 0);
    chk("clr_terr", timeout_err, 0);

    // Clamp to MAX_BURST.
    dn_req = 1'b1; dn_frames = 5'd31;
    wait_gnt(10);
    wait_done(400, cyc);
    chk("clamp_cnt", frame_cnt, MAX_BURST);
    chk("clamp_len", cyc, MAX_BURST * DN_BITS);
    dn_req = 1'b0;

    // Zero-frame request is ignored.
    up_req = 1'b1; up_frames = 5'd0; any_gnt = 0;
    repeat (10) begin @(negedge clk); any_gnt |= (up_gnt | dn_gnt); end
    chk("zero_no_grant", any_gnt, 0);
    up_req = 1'b0;

    // Reset in the middle of a burst.
    up_req = 1'b1; up_frames = 5'd5;
    wait_gnt(10);
    repeat (30) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    chk("midrst_gnt", up_gnt, 0);
    chk("midrst_updown", updown, 0);
    chk("midrst_cnt", frame_cnt, 0);
    chk("midrst_done", burst_done, 0);
    rst = 1'b0; up_req = 1'b0;

    // Random traffic.
    run_left = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin up_req = ~up_req; up_frames = 5'($urandom_range(0, 31)); end
      if ($urandom_range(0, 29) == 0) begin dn_req = ~dn_req; dn_frames = 5'($urandom_range(0, 31)); end
      if (run_left == 0) begin
        if (sen) begin sen = 1'b0; run_left = $urandom_range(1, 80); end
        else begin
          sen = 1'b1;
          run_left = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 3);
        end
      end else run_left--;
      err_clr = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 1999) == 0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
